adxl362_spi_slave: RTL and testbench

Synthesizable SPI responder modelling the ADXL362 register interface; the slave-side counterpart of the Wishbone SPI master used in the accelerometer test environment.
- Decodes ADXL362 write-register (0x0A) and read-register (0x0B) commands with address auto-increment.
- Serves ID, status and sample-data registers from sample ports and exposes writes to the host side.
- Lets the SPI master and driver software be exercised against RTL rather than a behavioural model.

---
 rtl/adxl362_pkg.sv | 50 +++++
 rtl/adxl362_spi_sync.sv | 45 ++++
 rtl/adxl362_spi_slave.sv | 206 ++++++++++++++++++++
 tb/tb_adxl362_spi_slave.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_pkg.sv
// Shared constants for the ADXL362 SPI register responder: command codes,
// register addresses, soft-reset key, FSM state encoding and the sample record.
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE       = 8'h0A;
  localparam logic [7:0] CMD_READ        = 8'h0B;

  localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
  localparam logic [7:0] ADDR_PARTID     = 8'h02;
  localparam logic [7:0] ADDR_REVID      = 8'h03;
  localparam logic [7:0] ADDR_XDATA      = 8'h08;
  localparam logic [7:0] ADDR_YDATA      = 8'h09;
  localparam logic [7:0] ADDR_ZDATA      = 8'h0A;
  localparam logic [7:0] ADDR_STATUS     = 8'h0B;
  localparam logic [7:0] ADDR_XDATA_L    = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H    = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L    = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H    = 8'h11;
  localparam logic [7:0] ADDR_ZDATA_L    = 8'h12;
  localparam logic [7:0] ADDR_ZDATA_H    = 8'h13;
  localparam logic [7:0] ADDR_TEMP_L     = 8'h14;
  localparam logic [7:0] ADDR_TEMP_H     = 8'h15;
  localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
  localparam logic [7:0] ADDR_ABORT_CNT  = 8'h3F;
  localparam logic [3:0] RW_PAGE         = 4'h2;   // 0x20..0x2E share the upper nibble
  localparam logic [3:0] RW_POWER_CTL    = 4'hD;   // 0x2D

  localparam logic [7:0] SOFT_RESET_KEY  = 8'h52;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_IGNORE = 3'd4;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
    logic [11:0] t;
  } sample_t;

  // Upper byte of a 12-bit two's complement value sign-extended to 16 bits.
  function automatic logic [7:0] sext_hi(input logic [11:0] v);
    return {{4{v[11]}}, v[11:8]};
  endfunction

endpackage

// File: rtl/adxl362_spi_sync.sv
// Synchronizes the asynchronous SPI pins into clk_i and derives edge strobes.
// csn resets high so that leaving reset never looks like a chip-select fall.
module adxl362_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic csn_i,
  input  logic mosi_i,
  output logic sck_rise,
  output logic sck_fall,
  output logic csn_fall,
  output logic csn_rise,
  output logic csn_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_q, csn_q, mosi_q;
  logic                   sck_d, csn_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_q  <= '0;
      csn_q  <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      csn_d  <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck_i};
      csn_q  <= {csn_q[SYNC_STAGES-2:0], csn_i};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sck_d  <= sck_q[SYNC_STAGES-1];
      csn_d  <= csn_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
  assign csn_fall = ~csn_q[SYNC_STAGES-1] & csn_d;
  assign csn_rise = csn_q[SYNC_STAGES-1] & ~csn_d;
  assign csn_s    = csn_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/adxl362_spi_slave.sv
// ADXL362-compatible SPI mode-0 register responder running entirely on clk_i.
// Define ADXL362_ABORT_CNT_EN to add a saturating aborted-transfer counter at 0x3F.
module adxl362_spi_slave
  import adxl362_pkg::*;
#(
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter logic [7:0] REVID       = 8'h01,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sck_i,
  input  logic        csn_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  input  logic [11:0] sample_x_i,
  input  logic [11:0] sample_y_i,
  input  logic [11:0] sample_z_i,
  input  logic [11:0] sample_t_i,
  input  logic        sample_valid_i,
  output logic        wr_strobe_o,
  output logic [7:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic [7:0]  power_ctl_o,
  output logic        soft_reset_o
);

  logic       sck_rise, sck_fall, csn_fall, csn_rise, csn_s, mosi_s;
  state_t     state_q;
  logic [2:0] bitcnt_q;
  logic [6:0] rx_q;
  logic [7:0] rx_next, tx_q, addr_q;
  logic       is_read_q, data_ready_q, pend_vld_q;
  logic [7:0] rw_q [16];
  sample_t    shad_q, pend_q, sample_in;
  logic       bit_evt, byte_done, rd_done, wr_done, soft_rst_hit, dr_clear;
`ifdef ADXL362_ABORT_CNT_EN
  logic [7:0] abort_cnt_q;
`endif

  adxl362_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sck_i    (sck_i),
    .csn_i    (csn_i),
    .mosi_i   (mosi_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .csn_fall (csn_fall),
    .csn_rise (csn_rise),
    .csn_s    (csn_s),
    .mosi_s   (mosi_s)
  );

  function automatic logic is_rw(input logic [7:0] a);
    return (a[7:4] == RW_PAGE) && (a[3:0] != 4'hF);
  endfunction

  function automatic logic [7:0] reg_read(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (is_rw(a)) v = rw_q[a[3:0]];
    else begin
      case (a)
        ADDR_DEVID_AD:  v = DEVID_AD;
        ADDR_DEVID_MST: v = DEVID_MST;
        ADDR_PARTID:    v = PARTID;
        ADDR_REVID:     v = REVID;
        ADDR_XDATA:     v = shad_q.x[11:4];
        ADDR_YDATA:     v = shad_q.y[11:4];
        ADDR_ZDATA:     v = shad_q.z[11:4];
        ADDR_STATUS:    v = {7'b0, data_ready_q};
        ADDR_XDATA_L:   v = shad_q.x[7:0];
        ADDR_XDATA_H:   v = sext_hi(shad_q.x);
        ADDR_YDATA_L:   v = shad_q.y[7:0];
        ADDR_YDATA_H:   v = sext_hi(shad_q.y);
        ADDR_ZDATA_L:   v = shad_q.z[7:0];
        ADDR_ZDATA_H:   v = sext_hi(shad_q.z);
        ADDR_TEMP_L:    v = shad_q.t[7:0];
        ADDR_TEMP_H:    v = sext_hi(shad_q.t);
`ifdef ADXL362_ABORT_CNT_EN
        ADDR_ABORT_CNT: v = abort_cnt_q;
`endif
        default:        v = 8'h00;
      endcase
    end
    return v;
  endfunction

  // A chip-select edge always wins over a coincident sck rise.
  assign rx_next      = {rx_q, mosi_s};
  assign bit_evt      = sck_rise && !csn_rise && !csn_fall && (state_q != ST_IDLE);
  assign byte_done    = bit_evt && (bitcnt_q == 3'd7);
  assign rd_done      = byte_done && (state_q == ST_DATA) && is_read_q;
  assign wr_done      = byte_done && (state_q == ST_DATA) && !is_read_q;
  assign soft_rst_hit = wr_done && (addr_q == ADDR_SOFT_RESET) && (rx_next == SOFT_RESET_KEY);
  assign dr_clear     = rd_done && (addr_q == ADDR_STATUS);
  assign sample_in    = '{x: sample_x_i, y: sample_y_i, z: sample_z_i, t: sample_t_i};

  assign miso_o      = (state_q == ST_DATA) && is_read_q && tx_q[7];
  assign miso_oe_o   = ~csn_s;
  assign power_ctl_o = rw_q[RW_POWER_CTL];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= 3'd0;
      rx_q         <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      is_read_q    <= 1'b0;
      wr_strobe_o  <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      soft_reset_o <= 1'b0;
    end else begin
      wr_strobe_o  <= 1'b0;
      soft_reset_o <= soft_rst_hit;
      // Skipping the shift at bitcnt 0 keeps the freshly loaded MSB on MISO.
      if (sck_fall && (bitcnt_q != 3'd0)) tx_q <= {tx_q[6:0], 1'b0};
      if (csn_rise) begin
        state_q  <= ST_IDLE;
        bitcnt_q <= 3'd0;
      end else if (csn_fall) begin
        state_q  <= ST_CMD;
        bitcnt_q <= 3'd0;
      end else if (bit_evt) begin
        rx_q     <= rx_next[6:0];
        bitcnt_q <= bitcnt_q + 3'd1;
      end
      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            is_read_q <= (rx_next == CMD_READ);
            state_q   <= ((rx_next == CMD_READ) || (rx_next == CMD_WRITE)) ? ST_ADDR : ST_IGNORE;
          end
          ST_ADDR: begin
            addr_q  <= rx_next;
            state_q <= ST_DATA;
            if (is_read_q) tx_q <= reg_read(rx_next);
          end
          ST_DATA: begin
            addr_q <= addr_q + 8'd1;
            if (is_read_q) tx_q <= reg_read(addr_q + 8'd1);
            else begin
              wr_strobe_o <= 1'b1;
              wr_addr_o   <= addr_q;
              wr_data_o   <= rx_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 16; i++) rw_q[i] <= '0;
    end else if (soft_rst_hit) begin
      for (int i = 0; i < 16; i++) rw_q[i] <= '0;
    end else if (wr_done && is_rw(addr_q)) begin
      rw_q[addr_q[3:0]] <= rx_next;
    end
  end

  // Samples arriving mid-transfer are parked so a burst read stays coherent.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shad_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      if (dr_clear || soft_rst_hit) data_ready_q <= 1'b0;
      if (soft_rst_hit) pend_vld_q <= 1'b0;
      if (csn_rise && pend_vld_q) begin
        shad_q       <= pend_q;
        data_ready_q <= 1'b1;
        pend_vld_q   <= 1'b0;
      end
      if (sample_valid_i) begin
        if (csn_s) begin
          shad_q       <= sample_in;
          data_ready_q <= 1'b1;
        end else begin
          pend_q     <= sample_in;
          pend_vld_q <= 1'b1;
        end
      end
    end
  end

`ifdef ADXL362_ABORT_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) abort_cnt_q <= '0;
    else if (soft_rst_hit) abort_cnt_q <= '0;
    else if (csn_rise && ((bitcnt_q != 3'd0) || (state_q == ST_IGNORE)) && (abort_cnt_q != 8'hFF))
      abort_cnt_q <= abort_cnt_q + 8'd1;
  end
`endif

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// Directed bench for adxl362_spi_slave: table of register transactions plus
// hand-written sequences for sample coherency, aborts, soft reset and rst_i.
module tb_adxl362_spi_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic        miso_o, miso_oe_o, wr_strobe_o, soft_reset_o;
  logic [7:0]  wr_addr_o, wr_data_o, power_ctl_o;
  logic [11:0] sx = '0, sy = '0, sz = '0, st = '0;
  logic        svalid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int srst_cnt = 0;
  logic [15:0] wr_log[$];

  always #5 clk = ~clk;

  adxl362_spi_slave dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .sck_i          (sck),
    .csn_i          (csn),
    .mosi_i         (mosi),
    .miso_o         (miso_o),
    .miso_oe_o      (miso_oe_o),
    .sample_x_i     (sx),
    .sample_y_i     (sy),
    .sample_z_i     (sz),
    .sample_t_i     (st),
    .sample_valid_i (svalid),
    .wr_strobe_o    (wr_strobe_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .power_ctl_o    (power_ctl_o),
    .soft_reset_o   (soft_reset_o)
  );

  always @(negedge clk) begin
    if (wr_strobe_o) wr_log.push_back({wr_addr_o, wr_data_o});
    if (soft_reset_o) srst_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_valid();
    svalid = 1'b1;
    clks(1);
    svalid = 1'b0;
    clks(1);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      clks(HALF);
      rx = {rx[6:0], miso_o};
      sck = 1'b1;
      clks(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic xact(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                      input logic [31:0] wd, input int pulse_at, output logic [31:0] rd);
    logic [7:0] b;
    rd = '0;
    csn = 1'b0;
    clks(HALF);
    spi_byte(cmd, 8, b);
    spi_byte(addr, 8, b);
    for (int i = 0; i < n; i++) begin
      if (i == pulse_at) pulse_valid();
      spi_byte(wd[8*(n-1-i) +: 8], 8, b);
      rd = {rd[23:0], b};
    end
    clks(HALF);
    csn = 1'b1;
    clks(HALF);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input int n, input logic [31:0] exp);
    logic [31:0] rd;
    xact(8'h0B, addr, n, 32'h0, -1, rd);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [7:0] addr, input int n, input logic [31:0] wd);
    logic [31:0] rd;
    xact(8'h0A, addr, n, wd, -1, rd);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    int          n;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          pre;
    logic [7:0]  abort_one, abort_two;
`ifdef ADXL362_ABORT_CNT_EN
    abort_one = 8'h01;
    abort_two = 8'h02;
`else
    abort_one = 8'h00;
    abort_two = 8'h00;
`endif

    tbl[0]  = '{8'h0B, 8'h00, 4, 32'h0,    32'hAD1DF201};
    tbl[1]  = '{8'h0B, 8'h02, 2, 32'h0,    32'h0000F201};
    tbl[2]  = '{8'h0B, 8'h03, 2, 32'h0,    32'h00000100};
    tbl[3]  = '{8'h0B, 8'hFF, 2, 32'h0,    32'h000000AD};
    tbl[4]  = '{8'h0B, 8'h0B, 1, 32'h0,    32'h00000000};
    tbl[5]  = '{8'h0B, 8'h0E, 4, 32'h0,    32'h00000000};
    tbl[6]  = '{8'h0A, 8'h2D, 2, 32'h0215, 32'h00000000};
    tbl[7]  = '{8'h0B, 8'h2D, 2, 32'h0,    32'h00000215};
    tbl[8]  = '{8'h0A, 8'h20, 1, 32'h5A,   32'h00000000};
    tbl[9]  = '{8'h0A, 8'h30, 1, 32'h55,   32'h00000000};
    tbl[10] = '{8'h0B, 8'h30, 1, 32'h0,    32'h00000000};
    tbl[11] = '{8'h0B, 8'h1F, 1, 32'h0,    32'h00000000};
    tbl[12] = '{8'h0B, 8'h20, 1, 32'h0,    32'h0000005A};
    tbl[13] = '{8'h0B, 8'h2E, 2, 32'h0,    32'h00001500};

    // reset state
    clks(3);
    check("rst miso", 32'(miso_o), 32'h0);
    check("rst miso_oe", 32'(miso_oe_o), 32'h0);
    check("rst wr_strobe", 32'(wr_strobe_o), 32'h0);
    check("rst wr_addr", 32'(wr_addr_o), 32'h0);
    check("rst wr_data", 32'(wr_data_o), 32'h0);
    check("rst power_ctl", 32'(power_ctl_o), 32'h0);
    check("rst soft_reset", 32'(soft_reset_o), 32'h0);
    rst_n = 1'b1;
    clks(4);

    // output enable follows synchronized chip select
    csn = 1'b0;
    clks(4);
    check("oe during csn low", 32'(miso_oe_o), 32'h1);
    csn = 1'b1;
    clks(4);
    check("oe after csn high", 32'(miso_oe_o), 32'h0);

    for (int v = 0; v < 14; v++) begin
      pre = wr_log.size();
      xact(tbl[v].cmd, tbl[v].addr, tbl[v].n, tbl[v].wd, -1, rd);
      check($sformatf("vec%0d data", v), rd, tbl[v].exp);
      if (tbl[v].cmd == 8'h0A) begin
        check($sformatf("vec%0d strobes", v), 32'(wr_log.size() - pre), 32'(tbl[v].n));
        if (wr_log.size() - pre == tbl[v].n)
          for (int j = 0; j < tbl[v].n; j++)
            check($sformatf("vec%0d strobe%0d", v, j), 32'(wr_log[pre+j]),
                  32'({tbl[v].addr + 8'(j), tbl[v].wd[8*(tbl[v].n-1-j) +: 8]}));
      end
    end
    check("power_ctl after write", 32'(power_ctl_o), 32'h02);

    // sample shadows and DATA_READY
    sx = 12'hF80; sy = 12'h7FF; sz = 12'h800; st = 12'h00A;
    pulse_valid();
    rd_chk("x lo/hi", 8'h0E, 2, 32'h80FF);
    rd_chk("x 8-bit", 8'h08, 1, 32'hF8);
    rd_chk("y/z 8-bit", 8'h09, 2, 32'h7F80);
    rd_chk("y/z 16-bit", 8'h10, 4, 32'hFF0700F8);
    rd_chk("temp", 8'h14, 2, 32'h0A00);
    rd_chk("status set", 8'h0B, 1, 32'h01);
    rd_chk("status cleared", 8'h0B, 1, 32'h00);

    // sample arriving mid-burst is held until csn rise
    sx = 12'h123;
    xact(8'h0B, 8'h0E, 2, 32'h0, 1, rd);
    check("coherent burst", rd, 32'h80FF);
    rd_chk("pending committed", 8'h0E, 2, 32'h2301);
    rd_chk("status after commit", 8'h0B, 1, 32'h01);

    // aborted write after 5 data bits
    pre = wr_log.size();
    csn = 1'b0;
    clks(HALF);
    spi_byte(8'h0A, 8, b);
    spi_byte(8'h20, 8, b);
    spi_byte(8'hFF, 5, b);
    clks(HALF);
    csn = 1'b1;
    clks(HALF);
    check("abort no strobe", 32'(wr_log.size() - pre), 32'h0);
    rd_chk("abort reg kept", 8'h20, 1, 32'h5A);
    rd_chk("abort count 1", 8'h3F, 1, 32'(abort_one));

    // unknown command is ignored
    pre = wr_log.size();
    xact(8'h0C, 8'h20, 2, 32'hFFFF, -1, rd);
    check("ignore miso", rd, 32'h0);
    check("ignore no strobe", 32'(wr_log.size() - pre), 32'h0);
    rd_chk("ignore reg kept", 8'h20, 1, 32'h5A);
    rd_chk("abort count 2", 8'h3F, 1, 32'(abort_two));

    // soft reset
    pulse_valid();
    wr(8'h1F, 1, 32'h11);
    check("wrong key no pulse", 32'(srst_cnt), 32'h0);
    check("wrong key power_ctl", 32'(power_ctl_o), 32'h02);
    wr(8'h1F, 1, 32'h52);
    check("soft reset pulse", 32'(srst_cnt), 32'h1);
    check("soft reset strobe", 32'(wr_log[wr_log.size()-1]), 32'h1F52);
    check("soft reset power_ctl", 32'(power_ctl_o), 32'h00);
    rd_chk("soft reset rw", 8'h20, 1, 32'h00);
    rd_chk("soft reset 2D", 8'h2D, 2, 32'h0000);
    rd_chk("soft reset status", 8'h0B, 1, 32'h00);
    rd_chk("soft reset shadows", 8'h0E, 2, 32'h2301);
    rd_chk("soft reset ids", 8'h00, 1, 32'hAD);
    rd_chk("soft reset abort", 8'h3F, 1, 32'h00);

    // rst_i asserted mid-read
    wr(8'h2D, 1, 32'h0C);
    check("power_ctl before rst", 32'(power_ctl_o), 32'h0C);
    csn = 1'b0;
    clks(HALF);
    spi_byte(8'h0B, 8, b);
    spi_byte(8'h00, 8, b);
    spi_byte(8'h00, 3, b);
    rst_n = 1'b0;
    clks(2);
    check("mid rst miso", 32'(miso_o), 32'h0);
    check("mid rst miso_oe", 32'(miso_oe_o), 32'h0);
    check("mid rst wr_strobe", 32'(wr_strobe_o), 32'h0);
    check("mid rst wr_addr", 32'(wr_addr_o), 32'h0);
    check("mid rst wr_data", 32'(wr_data_o), 32'h0);
    check("mid rst power_ctl", 32'(power_ctl_o), 32'h0);
    check("mid rst soft_reset", 32'(soft_reset_o), 32'h0);
    csn = 1'b1;
    clks(2);
    rst_n = 1'b1;
    clks(4);
    rd_chk("after rst ids", 8'h00, 2, 32'hAD1D);
    rd_chk("after rst 2D", 8'h2D, 1, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
